phy_rx_sync_ctrl: RTL and testbench

PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

---
 rtl/phy_rx_defs.sv | 25 ++
 rtl/lane_sync.sv | 123 ++++++++++++
 rtl/phy_rx_sync_ctrl.sv | 67 ++++++
 tb/tb_phy_rx_sync_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/phy_rx_defs.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_defs (package)
//  Description : Shared constants and lane state encoding for the two-lane
//                serial receive synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_rx_defs;

  // Consecutive aligned commas needed before a lane is declared active
  localparam int         BC_LOCK_DEFAULT = 4;

  // Alignment / idle symbol
  localparam logic [7:0] COMMA_SYMBOL    = 8'hBC;

  // Per-lane synchroniser states; the encoding is visible on lane_state
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SEARCH = 2'd1,
    ST_ALIGN  = 2'd2,
    ST_ACTIVE = 2'd3
  } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/lane_sync.sv
`default_nettype none
// ============================================================================
//  Module      : lane_sync
//  Description : One serial lane: bit shifter, comma search, byte alignment
//                lock and aligned byte delivery with a data strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_sync
  import phy_rx_defs::*;
#(
  parameter int         BC_LOCK = BC_LOCK_DEFAULT,
  parameter logic [7:0] COMMA   = COMMA_SYMBOL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       resync,
  output logic       active,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [1:0] state
);

  localparam int             CW       = $clog2(BC_LOCK + 1);
  localparam logic [CW-1:0]  LOCK_VAL = CW'(BC_LOCK);

  lane_state_t   r_state;
  lane_state_t   w_state_nxt;
  // Only the last seven bits are kept: with the incoming bit they form the
  // full 8-bit shift value, which is all that is ever compared or captured.
  logic [6:0]    r_sr;
  logic [7:0]    w_sr_nxt;
  logic [2:0]    r_bit_cnt;
  logic [2:0]    w_bit_cnt_nxt;
  logic [CW-1:0] r_bc_cnt;
  logic [CW-1:0] w_bc_cnt_nxt;
  logic [CW-1:0] w_bc_inc;
  logic          w_boundary;
  logic          w_is_comma;
  logic          w_capture;

  assign w_sr_nxt   = {r_sr, data_in};
  assign w_is_comma = (w_sr_nxt == COMMA);
  // The edge on which bit_cnt wraps 7->0 completes a byte
  assign w_boundary = (r_bit_cnt == 3'd7);
  assign w_bc_inc   = (r_bc_cnt >= LOCK_VAL) ? LOCK_VAL : r_bc_cnt + CW'(1);
  assign state      = r_state;

  // State, bit counter and comma counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_bit_cnt <= 3'd0;
      r_bc_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bc_cnt  <= w_bc_cnt_nxt;
    end
  end

  // Next-state logic: resync overrides everything, including a boundary
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_capture     = 1'b0;
    if (resync) begin
      w_state_nxt  = ST_SEARCH;
      w_bc_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_RESET: w_state_nxt = ST_SEARCH;
        ST_SEARCH: begin
          if (w_is_comma) begin
            w_bit_cnt_nxt = 3'd0;
            w_bc_cnt_nxt  = CW'(1);
            w_state_nxt   = ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (w_boundary) begin
            if (w_is_comma) begin
              w_bc_cnt_nxt = w_bc_inc;
              if (w_bc_inc == LOCK_VAL) begin
                w_state_nxt = ST_ACTIVE;
              end
            end else begin
              w_bc_cnt_nxt = '0;
              w_state_nxt  = ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: w_capture = w_boundary;
        default:   w_state_nxt = ST_RESET;
      endcase
    end
  end

  // Shift register, byte capture, data strobe and registered lock status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr       <= 7'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      active     <= 1'b0;
    end else begin
      r_sr <= w_sr_nxt[6:0];
      if (w_capture) begin
        byte_out <= w_sr_nxt;
      end
      if (resync) begin
        byte_valid <= 1'b0;
        active     <= 1'b0;
      end else begin
        byte_valid <= w_capture && !w_is_comma;
        active     <= (r_state == ST_ACTIVE);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/phy_rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_sync_ctrl
//  Description : Two independent serial lane synchronisers with a shared
//                resync request, a combined link status and a debug view of
//                both lane states. No deskew between lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_sync_ctrl
  import phy_rx_defs::*;
#(
  parameter int         BC_LOCK = BC_LOCK_DEFAULT,
  parameter logic [7:0] COMMA   = COMMA_SYMBOL
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       Data_in_0,
  input  logic       Data_in_1,
  input  logic       resync,
  output logic       active_0,
  output logic       active_1,
  output logic [7:0] byte_0,
  output logic [7:0] byte_1,
  output logic       byte_valid_0,
  output logic       byte_valid_1,
  output logic       link_active,
  output logic [3:0] lane_state
);

  logic [1:0] w_state_0;
  logic [1:0] w_state_1;

  lane_sync #(.BC_LOCK(BC_LOCK), .COMMA(COMMA)) u_lane_0 (
    .clk        (clk_32f),
    .rst_n      (reset),
    .data_in    (Data_in_0),
    .resync     (resync),
    .active     (active_0),
    .byte_out   (byte_0),
    .byte_valid (byte_valid_0),
    .state      (w_state_0)
  );

  lane_sync #(.BC_LOCK(BC_LOCK), .COMMA(COMMA)) u_lane_1 (
    .clk        (clk_32f),
    .rst_n      (reset),
    .data_in    (Data_in_1),
    .resync     (resync),
    .active     (active_1),
    .byte_out   (byte_1),
    .byte_valid (byte_valid_1),
    .state      (w_state_1)
  );

  assign lane_state = {w_state_1, w_state_0};

  // Link is up one cycle after the later of the two lanes locks
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      link_active <= 1'b0;
    end else begin
      link_active <= active_0 & active_1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_sync_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_rx_sync_ctrl
//  Description : Directed, table-driven bench for the two-lane synchroniser.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_rx_sync_ctrl;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       Data_in_0;
  logic       Data_in_1;
  logic       resync;
  logic       active_0;
  logic       active_1;
  logic [7:0] byte_0;
  logic [7:0] byte_1;
  logic       byte_valid_0;
  logic       byte_valid_1;
  logic       link_active;
  logic [3:0] lane_state;

  phy_rx_sync_ctrl dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .Data_in_0    (Data_in_0),
    .Data_in_1    (Data_in_1),
    .resync       (resync),
    .active_0     (active_0),
    .active_1     (active_1),
    .byte_0       (byte_0),
    .byte_1       (byte_1),
    .byte_valid_0 (byte_valid_0),
    .byte_valid_1 (byte_valid_1),
    .link_active  (link_active),
    .lane_state   (lane_state)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       a0;
    logic       v0;
    logic [7:0] y0;
    logic       a1;
    logic       v1;
    logic [7:0] y1;
    logic       lnk;
    logic [3:0] ls;
  } vec_t;

  vec_t tbl [10];

  int n_cmp = 0;
  int n_err = 0;
  int s_cnt = 0;
  int first_a0 = 0;
  int first_a1 = 0;
  int first_lnk = 0;
  int mid_strobes = 0;
  int nv0 = 0;
  int nv1 = 0;
  int sv0 = 0;
  int sv1 = 0;
  logic [7:0] yv0 = 8'h00;
  logic [7:0] yv1 = 8'h00;
  logic [47:0] st0;
  logic [47:0] st1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bit per lane; outputs are sampled 1 time unit after the edge
  task automatic step(input logic d0, input logic d1, input logic rs);
    Data_in_0 = d0;
    Data_in_1 = d1;
    resync    = rs;
    @(posedge clk_32f);
    #1;
    s_cnt++;
    if (active_0 && first_a0 == 0) first_a0 = s_cnt;
    if (active_1 && first_a1 == 0) first_a1 = s_cnt;
    if (link_active && first_lnk == 0) first_lnk = s_cnt;
  endtask

  task automatic send_byte(input logic [7:0] b0, input logic [7:0] b1, input logic rs_last);
    for (int j = 0; j < 8; j++) begin
      step(b0[7-j], b1[7-j], rs_last && (j == 7));
      if (j < 7 && (byte_valid_0 || byte_valid_1)) mid_strobes++;
    end
  endtask

  task automatic clear_marks();
    s_cnt = 0;
    first_a0 = 0;
    first_a1 = 0;
    first_lnk = 0;
    mid_strobes = 0;
  endtask

  initial begin
    //        b0     b1     a0 v0 y0     a1 v1 y1     lnk ls
    tbl[0] = '{8'hBC, 8'hBC, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'hA};
    tbl[1] = '{8'hBC, 8'hBC, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'hA};
    tbl[2] = '{8'hBC, 8'h55, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'h6};
    tbl[3] = '{8'hBC, 8'hBC, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'hB};
    tbl[4] = '{8'h12, 8'hBC, 1, 1, 8'h12, 0, 0, 8'h00, 0, 4'hB};
    tbl[5] = '{8'h34, 8'hBC, 1, 1, 8'h34, 0, 0, 8'h00, 0, 4'hB};
    tbl[6] = '{8'hBC, 8'hBC, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 4'hF};
    tbl[7] = '{8'hA5, 8'h66, 1, 1, 8'hA5, 1, 1, 8'h66, 1, 4'hF};
    tbl[8] = '{8'hBC, 8'hBC, 1, 0, 8'hBC, 1, 0, 8'hBC, 1, 4'hF};
    tbl[9] = '{8'hA5, 8'h77, 1, 1, 8'hA5, 1, 1, 8'h77, 1, 4'hF};

    // Reset state
    reset = 1'b0;
    Data_in_0 = 1'b0;
    Data_in_1 = 1'b0;
    resync = 1'b0;
    repeat (3) @(posedge clk_32f);
    #1;
    chk("rst_lane_state", {28'd0, lane_state}, 32'h0);
    chk("rst_active", {30'd0, active_1, active_0}, 32'h0);
    chk("rst_bytes", {16'd0, byte_1, byte_0}, 32'h0);
    chk("rst_valid_link", {29'd0, link_active, byte_valid_1, byte_valid_0}, 32'h0);

    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("post_rst_search", {28'd0, lane_state}, 32'h5);

    // Table: lane0 locks on 4 BCs, lane1 is interrupted by 0x55 and relocks
    clear_marks();
    for (int k = 0; k < 10; k++) begin
      send_byte(tbl[k].b0, tbl[k].b1, 1'b0);
      chk($sformatf("tbl%0d_active0", k), {31'd0, active_0}, {31'd0, tbl[k].a0});
      chk($sformatf("tbl%0d_valid0", k), {31'd0, byte_valid_0}, {31'd0, tbl[k].v0});
      chk($sformatf("tbl%0d_byte0", k), {24'd0, byte_0}, {24'd0, tbl[k].y0});
      chk($sformatf("tbl%0d_active1", k), {31'd0, active_1}, {31'd0, tbl[k].a1});
      chk($sformatf("tbl%0d_valid1", k), {31'd0, byte_valid_1}, {31'd0, tbl[k].v1});
      chk($sformatf("tbl%0d_byte1", k), {24'd0, byte_1}, {24'd0, tbl[k].y1});
      chk($sformatf("tbl%0d_link", k), {31'd0, link_active}, {31'd0, tbl[k].lnk});
      chk($sformatf("tbl%0d_lane_state", k), {28'd0, lane_state}, {28'd0, tbl[k].ls});
    end
    chk("tbl_mid_byte_strobes", mid_strobes, 0);
    chk("tbl_active0_rise_step", first_a0, 33);
    chk("tbl_active1_rise_step", first_a1, 57);
    chk("tbl_link_rise_step", first_lnk, 58);

    // Resync on a boundary carrying data: no strobe, lanes drop to SEARCH
    clear_marks();
    send_byte(8'h42, 8'h42, 1'b1);
    chk("resync_valid", {30'd0, byte_valid_1, byte_valid_0}, 32'h0);
    chk("resync_active", {30'd0, active_1, active_0}, 32'h0);
    chk("resync_lane_state", {28'd0, lane_state}, 32'h5);
    send_byte(8'hBC, 8'hBC, 1'b0);
    chk("relock_bc1_state", {28'd0, lane_state}, 32'hA);
    chk("relock_bc1_link", {31'd0, link_active}, 32'h0);
    send_byte(8'hBC, 8'hBC, 1'b0);
    send_byte(8'hBC, 8'hBC, 1'b0);
    send_byte(8'hBC, 8'hBC, 1'b0);
    chk("relock_bc4_state", {28'd0, lane_state}, 32'hF);
    chk("relock_bc4_active", {30'd0, active_1, active_0}, 32'h0);
    send_byte(8'h99, 8'h88, 1'b0);
    chk("relock_data_valid", {30'd0, byte_valid_1, byte_valid_0}, 32'h3);
    chk("relock_data_bytes", {16'd0, byte_1, byte_0}, 32'h8899);
    chk("relock_active_link", {29'd0, link_active, active_1, active_0}, 32'h7);
    chk("relock_mid_strobes", mid_strobes, 0);

    // Asynchronous reset in the middle of a byte while active
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("async_rst_active_link", {29'd0, link_active, active_1, active_0}, 32'h0);
    chk("async_rst_bytes", {16'd0, byte_1, byte_0}, 32'h0);
    chk("async_rst_valid", {30'd0, byte_valid_1, byte_valid_0}, 32'h0);
    chk("async_rst_lane_state", {28'd0, lane_state}, 32'h0);
    @(posedge clk_32f);
    #1;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("rerelease_search", {28'd0, lane_state}, 32'h5);

    // Different garbage lead-in per lane: each locks at its own bit phase
    st0 = {3'b101,   32'hBCBCBCBC, 8'hE7, 5'b00000};
    st1 = {5'b11010, 32'hBCBCBCBC, 8'h18, 3'b000};
    clear_marks();
    for (int s = 1; s <= 48; s++) begin
      step(st0[48-s], st1[48-s], 1'b0);
      if (byte_valid_0) begin
        nv0++;
        sv0 = s_cnt;
        yv0 = byte_0;
      end
      if (byte_valid_1) begin
        nv1++;
        sv1 = s_cnt;
        yv1 = byte_1;
      end
    end
    chk("phase_active0_step", first_a0, 36);
    chk("phase_active1_step", first_a1, 38);
    chk("phase_link_step", first_lnk, 39);
    chk("phase_valid0_count", nv0, 1);
    chk("phase_valid0_step", sv0, 43);
    chk("phase_byte0", {24'd0, yv0}, 32'hE7);
    chk("phase_valid1_count", nv1, 1);
    chk("phase_valid1_step", sv1, 45);
    chk("phase_byte1", {24'd0, yv1}, 32'h18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
